// File: rtl/multicycle_sub_64.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_sub_64
//  Description : Multi-cycle unsigned subtractor, diff = A - B - bin. A
//                CHUNK_W-bit ripple-borrow slice is reused for WIDTH/CHUNK_W
//                cycles. The start/done handshake allows one operation at a
//                time. Defining SUB_OVF_EN enables the signed overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sub_64 #(
  parameter int WIDTH   = 64,
  parameter int CHUNK_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int c_NCHUNK = WIDTH / CHUNK_W;
  localparam int c_KW     = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
  localparam logic [c_KW-1:0] c_KLAST = c_KW'(c_NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [c_KW-1:0]  r_k;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;
  logic             r_bout;
  logic [CHUNK_W:0] w_sub;

  // Operands shift right each RUN cycle, so the active chunk is always the low slice.
  assign w_sub = {1'b0, r_a[CHUNK_W-1:0]} - {1'b0, r_b[CHUNK_W-1:0]}
               - {{CHUNK_W{1'b0}}, r_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_k      <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= bin;
            r_k      <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_diff[r_k*CHUNK_W +: CHUNK_W] <= w_sub[CHUNK_W-1:0];
          r_borrow <= w_sub[CHUNK_W];
          r_a      <= r_a >> CHUNK_W;
          r_b      <= r_b >> CHUNK_W;
          r_k      <= r_k + 1'b1;
          if (r_k == c_KLAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_bout  <= w_sub[CHUNK_W];
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SUB_OVF_EN
  logic r_ovf;

  // On the last chunk the low slice holds the operand sign bits and w_sub holds the result sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_RUN && r_k == c_KLAST) begin
      r_ovf <= (r_a[CHUNK_W-1] != r_b[CHUNK_W-1]) &&
               (w_sub[CHUNK_W-1] != r_a[CHUNK_W-1]);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sub_64.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_sub_64
//  Description : Randomized self-checking bench for multicycle_sub_64 against
//                a plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sub_64;

  localparam int c_W = 64;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [c_W-1:0] A;
  logic [c_W-1:0] B;
  logic           bin;
  logic           busy;
  logic           done;
  logic [c_W-1:0] diff;
  logic           bout;
  logic           ovf;

  int n_tests;
  int n_fail;

  multicycle_sub_64 #(.WIDTH(64), .CHUNK_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: full-width arithmetic with one extra bit for the borrow.
  function automatic logic [64:0] model_sub(input logic [63:0] a, input logic [63:0] b,
                                            input logic c);
    return {1'b0, a} - {1'b0, b} - {64'd0, c};
  endfunction

  function automatic logic model_ovf(input logic [63:0] a, input logic [63:0] b,
                                     input logic c);
    logic [64:0] r;
    r = model_sub(a, b, c);
`ifdef SUB_OVF_EN
    return (a[63] != b[63]) && (r[63] != a[63]);
`else
    return 1'b0;
`endif
  endfunction

  // Presents an operation and steps through its accept edge.
  task automatic issue(input logic [63:0] va, input logic [63:0] vb, input logic vbin);
    @(negedge clk);
    A = va; B = vb; bin = vbin; start = 1'b1;
    @(posedge clk); #1;
    check_val("accept_busy", {63'd0, busy}, 64'd1);
    start = 1'b0;
    A = {$urandom, $urandom}; B = {$urandom, $urandom}; bin = 1'($urandom);
  endtask

  // Waits for done after an accept; optionally injects a second start at cycle 2 and holds it.
  task automatic wait_check(input logic [63:0] va, input logic [63:0] vb, input logic vbin,
                            input bit inject, input logic [63:0] na, input logic [63:0] nb,
                            input logic nbin);
    int cyc;
    logic [64:0] r;
    r = model_sub(va, vb, vbin);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (inject && cyc == 2) begin
        A = na; B = nb; bin = nbin; start = 1'b1;
      end
    end
    check_val("latency", 64'(cyc), 64'd4);
    check_val("done", {63'd0, done}, 64'd1);
    check_val("diff", diff, r[63:0]);
    check_val("bout", {63'd0, bout}, {63'd0, r[64]});
    check_val("ovf", {63'd0, ovf}, {63'd0, model_ovf(va, vb, vbin)});
    @(posedge clk); #1;
    check_val("done_drop", {63'd0, done}, 64'd0);
    check_val("busy_drop", {63'd0, busy}, 64'd0);
    check_val("diff_hold", diff, r[63:0]);
  endtask

  task automatic run_op(input logic [63:0] va, input logic [63:0] vb, input logic vbin);
    issue(va, vb, vbin);
    wait_check(va, vb, vbin, 1'b0, 64'd0, 64'd0, 1'b0);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; bin = 1'b0;
    #1;
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_diff", diff, 64'd0);
    check_val("rst_bout", {63'd0, bout}, 64'd0);
    check_val("rst_ovf", {63'd0, ovf}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases
    run_op(64'd1005, 64'd69, 1'b1);
    run_op(64'd0, 64'd1, 1'b0);
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0);
    run_op(64'h0001_0000_0000_0000, 64'h0001_0000_0000_0000, 1'b0);
    run_op(64'h0001_0000_0000_0000, 64'd1, 1'b0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op(64'd5, 64'd5, 1'b1);

    // Start during busy is ignored; held start launches the next op right after done
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    wait_check(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
               1'b1, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001, 1'b1);
    @(posedge clk); #1;
    check_val("held_accept", {63'd0, busy}, 64'd1);
    start = 1'b0;
    wait_check(64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001, 1'b1,
               1'b0, 64'd0, 64'd0, 1'b0);

    // Reset mid-run aborts the operation immediately
    issue(64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", {63'd0, busy}, 64'd0);
    check_val("abort_done", {63'd0, done}, 64'd0);
    check_val("abort_diff", diff, 64'd0);
    check_val("abort_bout", {63'd0, bout}, 64'd0);
    repeat (4) begin
      @(posedge clk); #1;
      check_val("abort_nodone", {63'd0, done}, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check_val("post_rst_idle", {62'd0, busy, done}, 64'd0);
    end
    run_op(64'd1005, 64'd69, 1'b1);

    // Randomized operations with a mix of operand relationships
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = {$urandom, $urandom};
        1: rb = ra;
        2: rb = ra + 64'($urandom_range(0, 2));
        default: rb = {ra[63:16] ^ 48'(1 << $urandom_range(0, 47)), 16'($urandom)};
      endcase
      run_op(ra, rb, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
